// File: rtl/reg_cmd_initiator.sv
// Turns a valid/ready command stream into single-outstanding reg-bus transactions and returns
// the result on a valid/ready response stream; a watchdog converts hung transactions into errors.
module reg_cmd_initiator #(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type req_t = struct packed {
    logic [AW-1:0]   addr;
    logic            write;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            valid;
  },
  parameter type rsp_t = struct packed {
    logic [DW-1:0] rdata;
    logic          error;
    logic          ready;
  }
) (
  input  logic            src_clk_i,
  input  logic            src_rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic            cmd_write_i,
  input  logic [DW-1:0]   cmd_wdata_i,
  input  logic [DW/8-1:0] cmd_wstrb_i,
  output req_t            reg_req_o,
  input  rsp_t            reg_rsp_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_error_o,
  output logic            rsp_timeout_o
);

  // Counter only ever needs to reach TimeoutCycles-1; it saturates instead of wrapping.
  localparam int unsigned CW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CW-1:0] CntLast = CW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [CW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StOrphan
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_error_q, rsp_error_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            cmd_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    cmd_ready     = 1'b0;

    if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        // The response slot may be freed and refilled by the next command in the same cycle.
        cmd_ready = !rsp_valid_q || rsp_ready_i;
        if (cmd_valid_i && cmd_ready) begin
          addr_d  = cmd_addr_i;
          write_d = cmd_write_i;
          wdata_d = cmd_wdata_i;
          wstrb_d = cmd_wstrb_i;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (reg_rsp_i.ready) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = write_q ? '0 : reg_rsp_i.rdata;
          rsp_error_d   = reg_rsp_i.error;
          rsp_timeout_d = 1'b0;
          state_d       = StIdle;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = StOrphan;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StOrphan: begin
        // Request stays asserted until the responder finally answers; that answer is dropped.
        if (reg_rsp_i.ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    reg_req_o       = '0;
    reg_req_o.addr  = addr_q;
    reg_req_o.write = write_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = wstrb_q;
    reg_req_o.valid = (state_q != StIdle);
  end

  assign cmd_ready_o   = cmd_ready;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_error_o   = rsp_error_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_reg_cmd_initiator.sv
// Randomized bench for reg_cmd_initiator against a transaction-level model: each accepted command
// gets a responder delay; delay < TC gives the bus result, otherwise a watchdog error response.
module tb_reg_cmd_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TC = 8;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            write;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            valid;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          error;
    logic          ready;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic            cmd_write;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  req_t            reg_req;
  rsp_t            reg_rsp;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_error;
  logic            rsp_timeout;

  always #5 clk = ~clk;

  reg_cmd_initiator #(
    .AW(AW), .DW(DW), .TimeoutCycles(TC), .req_t(req_t), .rsp_t(rsp_t)
  ) dut (
    .src_clk_i(clk), .src_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_write_i(cmd_write),
    .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .reg_req_o(reg_req), .reg_rsp_i(reg_rsp),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error), .rsp_timeout_o(rsp_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: one open transaction plus one response slot.
  bit              m_open, m_timed, m_rv;
  int              m_k, m_delay;
  logic [AW-1:0]   m_addr;
  logic            m_write;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic            m_err, m_to;
  int              cmd_pct, rr_pct, dmin, dmax;
  int              n_acc, n_done, n_to;

  task automatic model_reset();
    m_open = 0; m_timed = 0; m_rv = 0; m_k = 0; m_delay = 0;
    m_rdata = '0; m_err = 0; m_to = 0;
  endtask

  task automatic drive_idle();
    cmd_valid = 0; cmd_addr = '0; cmd_write = 0; cmd_wdata = '0; cmd_wstrb = '0;
    reg_rsp = '0; rsp_ready = 0;
  endtask

  task automatic step();
    bit acc, fin, tmo;
    @(posedge clk);
    acc = cmd_valid && !m_open && (!m_rv || rsp_ready);
    fin = m_open && reg_rsp.ready;
    tmo = m_open && !reg_rsp.ready && !m_timed && (m_k == TC);
    if (m_rv && rsp_ready) begin
      m_rv = 0;
      n_done++;
    end
    if (fin && !m_timed) begin
      m_rv = 1; m_rdata = m_write ? '0 : reg_rsp.rdata; m_err = reg_rsp.error; m_to = 0;
    end
    if (tmo) begin
      m_rv = 1; m_rdata = '0; m_err = 1; m_to = 1; m_timed = 1; n_to++;
    end
    if (fin) m_open = 0;
    else if (m_open) m_k++;
    if (acc) begin
      m_open = 1; m_k = 1; m_timed = 0;
      m_addr = cmd_addr; m_write = cmd_write; m_wdata = cmd_wdata; m_wstrb = cmd_wstrb;
      m_delay = $urandom_range(dmax, dmin);
      n_acc++;
    end
    #1;
    // cmd fields change every cycle: only the accept-cycle values may matter.
    cmd_valid = ($urandom_range(99, 0) < cmd_pct);
    cmd_addr  = $urandom;
    cmd_write = 1'($urandom_range(1, 0));
    cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom_range(15, 0));
    reg_rsp.ready = m_open && (m_k == m_delay + 1);
    reg_rsp.rdata = $urandom;
    reg_rsp.error = 1'($urandom_range(1, 0));
    rsp_ready = ($urandom_range(99, 0) < rr_pct);
    @(negedge clk);
    check("reg_valid", reg_req.valid, m_open);
    if (m_open) begin
      check("reg_addr", reg_req.addr, m_addr);
      check("reg_write", reg_req.write, m_write);
      check("reg_wdata", reg_req.wdata, m_wdata);
      check("reg_wstrb", reg_req.wstrb, m_wstrb);
    end
    check("cmd_ready", cmd_ready, !m_open && (!m_rv || rsp_ready));
    check("rsp_valid", rsp_valid, m_rv);
    if (m_rv) begin
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("rsp_error", rsp_error, m_err);
      check("rsp_timeout", rsp_timeout, m_to);
    end
  endtask

  task automatic phase(input int cycles, input int cp, input int rp, input int lo, input int hi);
    cmd_pct = cp; rr_pct = rp; dmin = lo; dmax = hi;
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    bit found;
    n_acc = 0; n_done = 0; n_to = 0;
    model_reset();
    drive_idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_zero", (reg_req != '0), 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    check("rst_rsp_error", rsp_error, 1'b0);
    check("rst_rsp_timeout", rsp_timeout, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    rst_n = 1;

    phase(40, 100, 100, 0, 0);    // back-to-back, immediate responder
    phase(400, 60, 70, 0, 7);     // random normal completions
    phase(300, 70, 80, 6, 9);     // straddle the watchdog boundary
    phase(300, 70, 80, 8, 20);    // timeouts with late orphan answers
    phase(300, 80, 10, 0, 4);     // heavy response backpressure

    // Reset in the middle of a transaction.
    cmd_pct = 100; rr_pct = 50; dmin = 15; dmax = 20;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (m_open && m_k >= 2) found = 1;
    end
    check("rst_mid_found", found, 1'b1);
    #2 rst_n = 0;
    #1;
    check("rst_mid_reg_valid", reg_req.valid, 1'b0);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_rel_cmd_ready", cmd_ready, 1'b1);
    check("rst_rel_rsp_valid", rsp_valid, 1'b0);

    phase(300, 60, 60, 0, 12);

    check("some_accepts", (n_acc > 50), 1'b1);
    check("some_timeouts", (n_to > 5), 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
